// File: rtl/rf_wb_queue.sv
// rf_wb_queue: writeback buffer in front of the 32x32 register file.
// Accepts writeback results on a valid/ready handshake and drains them in
// order, one per cycle, onto the regfile write port. Writes to r0 are
// consumed without being stored.
// Optional feature macro: RF_WB_BYPASS_EN. When it is defined, a youngest-wins
// bypass lookup over the pending entries is built for two read ports. When it
// is undefined, the bypass outputs are tied to 0.
module rf_wb_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wb_valid,
    output logic          wb_ready,
    input  logic [4:0]    wb_addr,
    input  logic [31:0]   wb_data,
    input  logic          drain_en,
    output logic          rf_w,
    output logic [4:0]    waddr,
    output logic [31:0]   wdata,
    input  logic [4:0]    raddr1,
    input  logic [4:0]    raddr2,
    output logic          byp1_hit,
    output logic [31:0]   byp1_data,
    output logic          byp2_hit,
    output logic [31:0]   byp2_data,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full
);

    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    // Entry storage and queue pointers.
    logic [DEPTH-1:0][4:0]  addr_q, addr_d;
    logic [DEPTH-1:0][31:0] data_q, data_d;
    logic [AW-1:0]          head_q, head_d;
    logic [AW-1:0]          tail_q, tail_d;
    logic [AW:0]            count_q, count_d;

    logic push;
    logic pop;

    // Handshake, status and regfile write port, all from current state.
    // Reset suppresses the commit so nothing pending reaches the regfile in
    // the reset cycle.
    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CNT_FULL);
        pop      = drain_en && !empty && !rst;
        // A full queue still accepts when the head retires this cycle.
        wb_ready = !full || pop;
        // r0 writes complete the handshake but are never stored.
        push     = wb_valid && wb_ready && (wb_addr != 5'd0);
        rf_w     = pop;
        waddr    = 5'd0;
        wdata    = 32'd0;
        if (!empty) begin
            waddr = addr_q[head_q];
            wdata = data_q[head_q];
        end
        count    = count_q;
    end

    // Next-state: write at tail on push, retire head on pop; pointers wrap
    // naturally because DEPTH is a power of two.
    always_comb begin
        addr_d  = addr_q;
        data_d  = data_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) begin
            addr_d[tail_q] = wb_addr;
            data_d[tail_q] = wb_data;
            tail_d         = tail_q + AW'(1);
        end
        if (pop) begin
            head_d = head_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // State register; reset wins over any push/pop in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            data_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            addr_q  <= addr_d;
            data_q  <= data_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

`ifdef RF_WB_BYPASS_EN
    logic [AW-1:0] byp_idx;

    // Walk occupied entries oldest to youngest; later matches overwrite
    // earlier ones, so the youngest pending write for the address wins.
    always_comb begin
        byp_idx   = '0;
        byp1_hit  = 1'b0;
        byp1_data = 32'd0;
        byp2_hit  = 1'b0;
        byp2_data = 32'd0;
        for (int k = 0; k < DEPTH; k++) begin
            byp_idx = head_q + AW'(k);
            if ((AW+1)'(k) < count_q) begin
                if ((raddr1 != 5'd0) && (addr_q[byp_idx] == raddr1)) begin
                    byp1_hit  = 1'b1;
                    byp1_data = data_q[byp_idx];
                end
                if ((raddr2 != 5'd0) && (addr_q[byp_idx] == raddr2)) begin
                    byp2_hit  = 1'b1;
                    byp2_data = data_q[byp_idx];
                end
            end
        end
    end
`else
    // Without the lookup the hazard unit waits for empty; lookup addresses
    // are intentionally ignored.
    logic unused_raddr;
    assign unused_raddr = ^{raddr1, raddr2};

    // Bypass outputs held at zero.
    always_comb begin
        byp1_hit  = 1'b0;
        byp1_data = 32'd0;
        byp2_hit  = 1'b0;
        byp2_data = 32'd0;
    end
`endif

endmodule

// File: tb/tb_rf_wb_queue.sv
// Self-checking bench for rf_wb_queue: scoreboard of accepted writes,
// checked in order against every regfile commit.
module tb_rf_wb_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 2;
`ifdef RF_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          wb_valid;
    logic          wb_ready;
    logic [4:0]    wb_addr;
    logic [31:0]   wb_data;
    logic          drain_en;
    logic          rf_w;
    logic [4:0]    waddr;
    logic [31:0]   wdata;
    logic [4:0]    raddr1, raddr2;
    logic          byp1_hit, byp2_hit;
    logic [31:0]   byp1_data, byp2_data;
    logic [AW:0]   count;
    logic          empty, full;

    int total = 0;
    int bad   = 0;
    int commits = 0;
    logic [36:0] sb[$];

    rf_wb_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
        .drain_en(drain_en), .rf_w(rf_w), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2),
        .byp1_hit(byp1_hit), .byp1_data(byp1_data),
        .byp2_hit(byp2_hit), .byp2_data(byp2_data),
        .count(count), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    // Every commit must match the oldest outstanding accepted write.
    always @(negedge clk) begin
        if (rf_w === 1'b1) begin
            logic [36:0] exp_e;
            total++;
            commits++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL commit_unexpected: got addr=%0d data=%h, required no write", waddr, wdata);
            end else begin
                exp_e = sb.pop_front();
                if ({waddr, wdata} !== exp_e) begin
                    bad++;
                    $display("FAIL commit_order: got %0d/%h, required %0d/%h",
                             waddr, wdata, exp_e[36:32], exp_e[31:0]);
                end
            end
        end
    end

    // Present one request at posedge+1 and hold it until accepted.
    task automatic send(input logic [4:0] a, input logic [31:0] d);
        bit acc = 0;
        int n = 0;
        wb_valid = 1'b1; wb_addr = a; wb_data = d;
        while (!acc && n < 20) begin
            @(negedge clk);
            acc = (wb_ready === 1'b1);
            if (acc && a != 5'd0) sb.push_back({a, d});
            @(posedge clk); #1;
            n++;
        end
        wb_valid = 1'b0;
        total++;
        if (!acc) begin
            bad++;
            $display("FAIL send_timeout: addr=%0d not accepted within %0d cycles", a, n);
        end
    endtask

    task automatic drain_all();
        int n = 0;
        drain_en = 1'b1;
        @(negedge clk);
        while (empty !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (empty !== 1'b1 || sb.size() != 0) begin
            bad++;
            $display("FAIL drain_all: empty=%b outstanding=%0d, required empty=1 outstanding=0", empty, sb.size());
        end
        @(posedge clk); #1;
        drain_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; drain_en = 1'b1; wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
        raddr1 = 5'd3; raddr2 = 5'd4;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total++;
        if ({rf_w, empty, full, wb_ready, count, waddr, wdata} !== {1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 5'd0, 32'd0}) begin
            bad++;
            $display("FAIL reset_state: rf_w=%b empty=%b full=%b ready=%b count=%0d waddr=%0d wdata=%h",
                     rf_w, empty, full, wb_ready, count, waddr, wdata);
        end
        total++;
        if ({byp1_hit, byp2_hit, byp1_data, byp2_data} !== 66'd0) begin
            bad++;
            $display("FAIL reset_bypass: hit=%b%b data=%h/%h, required all 0", byp1_hit, byp2_hit, byp1_data, byp2_data);
        end
        @(posedge clk); #1;
        drain_en = 1'b0;
    endtask

    task automatic test_bypass();
        logic        eh;
        logic [31:0] ed1, ed2;
        send(5'd5, 32'h11111111);
        send(5'd5, 32'h22222222);
        send(5'd7, 32'h00000033);
        raddr1 = 5'd5; raddr2 = 5'd7;
        @(negedge clk);
        total++;
        if (count !== 3'd3) begin
            bad++;
            $display("FAIL bypass_count: got %0d, required 3", count);
        end
        eh  = BYP;
        ed1 = BYP ? 32'h22222222 : 32'd0;
        ed2 = BYP ? 32'h00000033 : 32'd0;
        total++;
        if (byp1_hit !== eh || byp1_data !== ed1) begin
            bad++;
            $display("FAIL bypass_youngest: got %b/%h, required %b/%h", byp1_hit, byp1_data, eh, ed1);
        end
        total++;
        if (byp2_hit !== eh || byp2_data !== ed2) begin
            bad++;
            $display("FAIL bypass_port2: got %b/%h, required %b/%h", byp2_hit, byp2_data, eh, ed2);
        end
        raddr1 = 5'd0;
        #1;
        total++;
        if (byp1_hit !== 1'b0 || byp1_data !== 32'd0) begin
            bad++;
            $display("FAIL bypass_r0: got %b/%h, required 0/0", byp1_hit, byp1_data);
        end
        @(posedge clk); #1;
        drain_all();
    endtask

    task automatic test_full();
        for (int i = 0; i < DEPTH; i++) send(5'(8 + i), 32'hF000_0000 + 32'(i));
        @(negedge clk);
        total++;
        if (full !== 1'b1 || wb_ready !== 1'b0 || count !== 3'd4) begin
            bad++;
            $display("FAIL full_state: full=%b ready=%b count=%0d, required 1/0/4", full, wb_ready, count);
        end
        @(posedge clk); #1;
        wb_valid = 1'b1; wb_addr = 5'd12; wb_data = 32'hC0C0C0C0; drain_en = 1'b1;
        @(negedge clk);
        total++;
        if (wb_ready !== 1'b1 || rf_w !== 1'b1) begin
            bad++;
            $display("FAIL full_push_pop: ready=%b rf_w=%b, required 1/1", wb_ready, rf_w);
        end
        if (wb_ready === 1'b1) sb.push_back({5'd12, 32'hC0C0C0C0});
        @(posedge clk); #1;
        wb_valid = 1'b0; drain_en = 1'b0;
        @(negedge clk);
        total++;
        if (count !== 3'd4 || full !== 1'b1) begin
            bad++;
            $display("FAIL full_count_kept: count=%0d full=%b, required 4/1", count, full);
        end
        @(posedge clk); #1;
        drain_all();
    endtask

    task automatic test_zero_addr();
        send(5'd3, 32'h33333333);
        wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'hDEADBEEF;
        @(negedge clk);
        total++;
        if (wb_ready !== 1'b1) begin
            bad++;
            $display("FAIL zero_ready: got %b, required 1", wb_ready);
        end
        @(posedge clk); #1;
        wb_valid = 1'b0;
        @(negedge clk);
        total++;
        if (count !== 3'd1) begin
            bad++;
            $display("FAIL zero_not_stored: count=%0d, required 1", count);
        end
        @(posedge clk); #1;
        drain_all();
    endtask

    task automatic test_back_to_back();
        int c0 = commits;
        drain_en = 1'b1;
        for (int i = 1; i <= 6; i++) send(5'(i), 32'hA000_0000 + 32'(i));
        drain_all();
        total++;
        if (commits - c0 != 6) begin
            bad++;
            $display("FAIL b2b_commits: got %0d, required 6", commits - c0);
        end
    endtask

    task automatic test_mid_reset();
        send(5'd9,  32'h09090909);
        send(5'd10, 32'h0A0A0A0A);
        send(5'd11, 32'h0B0B0B0B);
        @(negedge clk);
        total++;
        if (count !== 3'd3) begin
            bad++;
            $display("FAIL midrst_pending: count=%0d, required 3", count);
        end
        @(posedge clk); #1;
        rst = 1'b1; drain_en = 1'b1;
        sb.delete();
        @(negedge clk);
        total++;
        if (rf_w !== 1'b0) begin
            bad++;
            $display("FAIL midrst_no_write: rf_w=%b, required 0", rf_w);
        end
        @(posedge clk); #1;
        rst = 1'b0; raddr1 = 5'd9; raddr2 = 5'd10;
        @(negedge clk);
        total++;
        if (count !== 3'd0 || rf_w !== 1'b0 || empty !== 1'b1 || byp1_hit !== 1'b0 || byp2_hit !== 1'b0) begin
            bad++;
            $display("FAIL midrst_cleared: count=%0d rf_w=%b empty=%b hits=%b%b", count, rf_w, empty, byp1_hit, byp2_hit);
        end
        repeat (4) @(posedge clk);
        #1 drain_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_full();
        test_zero_addr();
        test_back_to_back();
        test_mid_reset();
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
